// File: rtl/imem_loader.sv
// Boot loader: parses a length-prefixed byte stream into 32-bit instruction memory writes
// and holds the core in reset until the image is complete. Optional checksum: IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int DEPTH = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        we,
    output logic [31:0] waddr,
    output logic [31:0] wdata,
    output logic        cpu_rst_n,
    output logic        done,
    output logic        err
);

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {S_HDR0, S_HDR1, S_DATA, S_CSUM, S_DONE, S_ERROR} state_t;
`else
    typedef enum logic [2:0] {S_HDR0, S_HDR1, S_DATA, S_DONE, S_ERROR} state_t;
`endif

    state_t      r_state;
    logic [7:0]  r_nlo;
    logic [15:0] r_last;
    logic [15:0] r_word_idx;
    logic [1:0]  r_byte_idx;
    logic [23:0] r_asm;
    logic        r_we;
    logic [31:0] r_waddr;
    logic [31:0] r_wdata;
    logic        r_done;
    logic        r_err;
    logic        r_cpu_rst_n;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  r_csum;
`endif

    logic        w_xfer;
    logic [15:0] w_n;
    logic        w_n_bad;

    assign w_xfer  = in_valid && in_ready;
    assign w_n     = {in_data, r_nlo};
    assign w_n_bad = (w_n == 16'd0) || (32'(w_n) > 32'(DEPTH));

    always_comb begin
        in_ready = 1'b0;
        case (r_state)
            S_HDR0, S_HDR1, S_DATA: in_ready = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CSUM:                 in_ready = 1'b1;
`endif
            default:                in_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_HDR0;
            r_nlo       <= 8'd0;
            r_last      <= 16'd0;
            r_word_idx  <= 16'd0;
            r_byte_idx  <= 2'd0;
            r_asm       <= 24'd0;
            r_we        <= 1'b0;
            r_waddr     <= 32'd0;
            r_wdata     <= 32'd0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_cpu_rst_n <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_csum      <= 8'd0;
`endif
        end else begin
            r_we <= 1'b0;
            case (r_state)
                S_HDR0: begin
                    if (w_xfer) begin
                        r_nlo   <= in_data;
                        r_state <= S_HDR1;
                    end
                end
                S_HDR1: begin
                    if (w_xfer) begin
                        r_last <= w_n - 16'd1;
                        if (w_n_bad) begin
                            r_state <= S_ERROR;
                            r_err   <= 1'b1;
                        end else begin
                            r_state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (w_xfer) begin
                        r_byte_idx <= r_byte_idx + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_csum     <= r_csum ^ in_data;
`endif
                        case (r_byte_idx)
                            2'd0: r_asm[7:0]   <= in_data;
                            2'd1: r_asm[15:8]  <= in_data;
                            2'd2: r_asm[23:16] <= in_data;
                            default: begin
                                // 4th byte completes the word; the write lands while the next byte streams in
                                r_we       <= 1'b1;
                                r_waddr    <= {14'd0, r_word_idx, 2'b00};
                                r_wdata    <= {in_data, r_asm};
                                r_word_idx <= r_word_idx + 16'd1;
                                if (r_word_idx == r_last) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                                    r_state     <= S_CSUM;
`else
                                    r_state     <= S_DONE;
                                    r_done      <= 1'b1;
                                    r_cpu_rst_n <= 1'b1;
`endif
                                end
                            end
                        endcase
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CSUM: begin
                    if (w_xfer) begin
                        if (in_data == r_csum) begin
                            r_state     <= S_DONE;
                            r_done      <= 1'b1;
                            r_cpu_rst_n <= 1'b1;
                        end else begin
                            r_state <= S_ERROR;
                            r_err   <= 1'b1;
                        end
                    end
                end
`endif
                S_DONE, S_ERROR: begin
                    if (start) begin
                        r_state     <= S_HDR0;
                        r_word_idx  <= 16'd0;
                        r_byte_idx  <= 2'd0;
                        r_done      <= 1'b0;
                        r_err       <= 1'b0;
                        r_cpu_rst_n <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_csum      <= 8'd0;
`endif
                    end
                end
                default: r_state <= S_HDR0;
            endcase
        end
    end

    assign we        = r_we;
    assign waddr     = r_waddr;
    assign wdata     = r_wdata;
    assign done      = r_done;
    assign err       = r_err;
    assign cpu_rst_n = r_cpu_rst_n;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: table vectors, reset corner cases, and randomized images
// checked against a word-level model of the stream format.
module tb_imem_loader;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst, start, in_valid;
    logic [7:0]  in_data;
    logic        in_ready, we, cpu_rst_n, done, err;
    logic [31:0] waddr, wdata;

    imem_loader #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .we(we), .waddr(waddr), .wdata(wdata),
        .cpu_rst_n(cpu_rst_n), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [63:0] wr_q[$];
    logic [63:0] exp_q[$];

    always @(negedge clk) if (we) wr_q.push_back({waddr, wdata});

    typedef struct {
        string       name;
        int          len;
        logic [95:0] bytes;
        bit          gap;
        bit          ok;
        int          nwr;
        logic [63:0] w0;
        logic [63:0] w1;
    } vec_t;

    function automatic vec_t mk(input string nm, input int len, input logic [95:0] b, input bit gap,
                                input bit ok, input int nwr, input logic [63:0] w0, input logic [63:0] w1);
        vec_t v;
        v.name = nm; v.len = len; v.bytes = b; v.gap = gap;
        v.ok = ok; v.nwr = nwr; v.w0 = w0; v.w1 = w1;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] b, input bit gap, input bit st);
        if (gap) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = 8'($urandom);
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        start    = st;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic chk_end(input string nm, input bit ok);
        chk({nm, "_done"}, 64'(done), 64'(ok));
        chk({nm, "_err"}, 64'(err), 64'(!ok));
        chk({nm, "_cpu_rst_n"}, 64'(cpu_rst_n), 64'(ok));
        chk({nm, "_in_ready"}, 64'(in_ready), 64'd0);
        chk({nm, "_nwr"}, 64'(wr_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++)
            chk($sformatf("%s_wr%0d", nm, i), wr_q[i], exp_q[i]);
    endtask

    task automatic restart(input string nm);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        settle();
        chk({nm, "_rearm_ready"}, 64'(in_ready), 64'd1);
        chk({nm, "_rearm_flags"}, {61'd0, done, err, cpu_rst_n}, 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Image of n random words; model is the list of (addr, word) pairs the stream describes.
    task automatic run_rand(input string nm, input int n, input bit rgap, input bit rstart, input bit csum_good);
        logic [31:0] w;
        logic [7:0]  x;
        bit          ok;
        x = 8'd0;
        ok = 1'b1;
        wr_q.delete();
        exp_q.delete();
        drive(8'(n), rgap && ($urandom_range(0, 1) == 1), 1'b0);
        drive(8'(n >> 8), rgap && ($urandom_range(0, 1) == 1), 1'b0);
        for (int k = 0; k < n; k++) begin
            w = $urandom;
            exp_q.push_back({32'(k * 4), w});
            for (int j = 0; j < 4; j++) begin
                x ^= w[8*j +: 8];
                drive(w[8*j +: 8], rgap && ($urandom_range(0, 1) == 1),
                      rstart && ($urandom_range(0, 3) == 0));
            end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        drive(csum_good ? x : (x ^ 8'h5A), 1'b0, 1'b0);
        ok = csum_good;
`else
        if (!csum_good) ok = 1'b1;
`endif
        settle();
        chk_end(nm, ok);
        restart(nm);
    endtask

    vec_t tbl[4];
    logic [7:0] b;
    logic [7:0] x;

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'd0;
        tbl[0] = mk("n2",       10, 96'h0000_0010_0593_0000_0513_0002, 1'b0, 1'b1, 2,
                    {32'h0, 32'h00000513}, {32'h4, 32'h00100593});
        tbl[1] = mk("n2_gap",   10, 96'h0000_0010_0593_0000_0513_0002, 1'b1, 1'b1, 2,
                    {32'h0, 32'h00000513}, {32'h4, 32'h00100593});
        tbl[2] = mk("hdr_zero",  2, 96'h0000, 1'b0, 1'b0, 0, 64'd0, 64'd0);
        tbl[3] = mk("hdr_1025",  2, 96'h0401, 1'b0, 1'b0, 0, 64'd0, 64'd0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_outputs", {we, done, err, cpu_rst_n}, 64'd0);
        chk("rst_waddr", 64'(waddr), 64'd0);
        chk("rst_wdata", 64'(wdata), 64'd0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        foreach (tbl[t]) begin
            wr_q.delete();
            exp_q.delete();
            if (tbl[t].nwr > 0) exp_q.push_back(tbl[t].w0);
            if (tbl[t].nwr > 1) exp_q.push_back(tbl[t].w1);
            x = 8'd0;
            for (int i = 0; i < tbl[t].len; i++) begin
                b = tbl[t].bytes[8*i +: 8];
                if (i >= 2) x ^= b;
                drive(b, tbl[t].gap, 1'b0);
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (tbl[t].ok) drive(x, tbl[t].gap, 1'b0);
`endif
            settle();
            chk_end(tbl[t].name, tbl[t].ok);
            restart(tbl[t].name);
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Bad checksum errors out, then a re-armed load with the right checksum succeeds
        wr_q.delete();
        exp_q.delete();
        exp_q.push_back(tbl[0].w0);
        exp_q.push_back(tbl[0].w1);
        for (int i = 0; i < 10; i++) begin
            b = tbl[0].bytes[8*i +: 8];
            drive(b, 1'b0, 1'b0);
        end
        drive(8'h00, 1'b0, 1'b0);
        settle();
        chk_end("csum_bad", 1'b0);
        restart("csum_bad");
        run_rand("csum_retry", 2, 1'b0, 1'b0, 1'b1);
`endif

        // Reset after 6 payload bytes: one write survives, load restarts from the header
        wr_q.delete();
        for (int i = 0; i < 8; i++) begin
            b = tbl[0].bytes[8*i +: 8];
            drive(b, 1'b0, 1'b0);
        end
        settle();
        do_reset();
        #1;
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        chk("midrst_flags", {61'd0, done, err, cpu_rst_n}, 64'd0);
        chk("midrst_nwr", 64'(wr_q.size()), 64'd1);
        if (wr_q.size() > 0) chk("midrst_wr0", wr_q[0], {32'h0, 32'h00000513});
        run_rand("after_rst", 2, 1'b0, 1'b0, 1'b1);

        // Reset landing on the cycle the write strobe is up cancels it
        wr_q.delete();
        drive(8'h01, 1'b0, 1'b0);
        drive(8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive(8'(8'hA0 + i), 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        chk("we_cancel", 64'(we), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("we_cancel_nwr", 64'(wr_q.size()), 64'd0);
        chk("we_cancel_ready", 64'(in_ready), 64'd1);

        for (int r = 0; r < 12; r++)
            run_rand($sformatf("rand%0d", r), $urandom_range(1, 6), 1'b1, 1'b1, ($urandom_range(0, 3) != 0));
        run_rand("n_depth", DEPTH, 1'b0, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
